// File: rtl/dot_stream_if.sv
// Handshake bundle for dot_stream.
//   Operand side : in_valid, in_ready, a, b, c, d, bias
//   Result side  : out_valid, out_ready, y
//   Status       : busy (result in flight or queued)
// master = producer/consumer environment, slave = dot_stream itself.
interface dot_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] bias;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;

  modport master (
    output in_valid, bias, a, b, c, d, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, bias, a, b, c, d, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/dot_stream.sv
// dot_stream: streaming signed dot product y = a*b + c*d + bias, truncated
// to WIDTH bits, through a fixed 3-stage pipeline into a DEPTH-entry FIFO.
// Issue is credit based: an operand set is accepted only when the FIFO is
// guaranteed to have room for it, so the pipeline never stalls.
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : dot_stream_if.slave (operand stream in, result stream out, busy)
module dot_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic          clock,
  input logic          reset,
  dot_stream_if.slave  bus
);
  localparam int PW = 2*WIDTH + 2;           // full-precision sum width
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Control state
  logic          v1, v2, v3;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Datapath state
  logic signed [WIDTH-1:0] a1, b1, c1, d1, bias1;
  logic signed [PW-1:0]    p_ab, p_cd, bias2, sum3;
  logic [WIDTH-1:0]        mem [DEPTH];

  logic          accept, pop, out_valid;
  logic [CW:0]   outstanding;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    outstanding = '0;
    out_valid   = 1'b0;
    outstanding = (CW+1)'(count) + (CW+1)'(v1) + (CW+1)'(v2) + (CW+1)'(v3);
    out_valid   = reset && (count != '0);
  end

  // Credits come from registered state only; in_valid never feeds back.
  assign bus.in_ready  = reset && (outstanding < (CW+1)'(DEPTH));
  assign bus.out_valid = out_valid;
  assign bus.y         = out_valid ? mem[rd_ptr] : '0;
  assign bus.busy      = reset && (v1 || v2 || v3 || (count != '0));

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = out_valid && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous cycle's value of the stage before it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      if (v3)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({v3, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: data registers and FIFO storage are not reset; the valid bits and
  // count alone decide whether their contents are ever looked at.
  always_ff @(posedge clock) begin
    a1    <= bus.a;
    b1    <= bus.b;
    c1    <= bus.c;
    d1    <= bus.d;
    bias1 <= bus.bias;
    // Sign-extend before multiplying so products and sum are exact.
    p_ab  <= PW'(a1) * PW'(b1);
    p_cd  <= PW'(c1) * PW'(d1);
    bias2 <= PW'(bias1);
    sum3  <= p_ab + p_cd + bias2;
    if (v3) mem[wr_ptr] <= sum3[WIDTH-1:0];
  end

  // Credits guarantee a free slot for every result leaving S3.
  a_no_full_write: assert property (
    @(posedge clock) disable iff (!reset) v3 |-> (count < CW'(DEPTH))
  );
endmodule

// File: tb/tb_dot_stream.sv
// Self-checking bench for dot_stream: a table of hand-computed vectors,
// hand-written corner sequences, and randomized traffic compared against
// a transaction-level model (queue of expected results with ready times).
module tb_dot_stream;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 4;   // accept cycle -> first cycle out_valid may be high

  logic clock = 1'b0;
  logic reset = 1'b0;

  dot_stream_if #(.WIDTH(W)) bus ();

  dot_stream #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] y;
    int           t;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b, c, d, bias;
    logic [W-1:0] exp_y;
  } vec_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, b, c, d, bias);
    int s;
    s = int'($signed(a)) * int'($signed(b)) + int'($signed(c)) * int'($signed(d))
      + int'($signed(bias));
    return s[W-1:0];
  endfunction

  // One clock cycle: drive inputs at the falling edge, check outputs against
  // the model, then record what the next rising edge will accept/pop.
  task automatic cycle(input logic rst_v, input logic iv,
                       input logic [W-1:0] ia, ib, ic, id, ibias,
                       input logic ordy,
                       output logic acc, output logic popd, output logic [W-1:0] ys);
    logic exp_ov;
    @(negedge clock);
    reset         = rst_v;
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.c         = ic;
    bus.d         = id;
    bus.bias      = ibias;
    bus.out_ready = ordy;
    #1;
    acc  = 1'b0;
    popd = 1'b0;
    ys   = bus.y;
    if (!rst_v) begin
      check("rst_in_ready",  bus.in_ready,  1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy",      bus.busy,      1'b0);
      check("rst_y",         bus.y,         '0);
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (cyc >= q[0].t + LAT);
      check("in_ready",  bus.in_ready,  q.size() < DEPTH);
      check("out_valid", bus.out_valid, exp_ov);
      check("busy",      bus.busy,      q.size() != 0);
      acc  = iv && bus.in_ready;
      popd = bus.out_valid && ordy;
      if (popd && q.size() > 0) begin
        check("y_order", bus.y, q[0].y);
        void'(q.pop_front());
      end
      if (acc) q.push_back('{y: ref_y(ia, ib, ic, id, ibias), t: cyc});
    end
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    logic acc, popd;
    logic [W-1:0] ys;
    cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, ordy, acc, popd, ys);
  endtask

  // Push one operand set, then collect its result; bounded waits.
  task automatic apply_one(input logic [W-1:0] a, b, c, d, bias,
                           output logic [W-1:0] ys, output logic done);
    logic acc, acc2, popd;
    logic [W-1:0] yv;
    int n;
    acc = 1'b0; popd = 1'b0; ys = '0; n = 0;
    while (!acc && n < 20) begin
      cycle(1'b1, 1'b1, a, b, c, d, bias, 1'b0, acc, popd, yv);
      n++;
    end
    n = 0;
    popd = 1'b0;
    while (acc && !popd && n < 20) begin
      cycle(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1, acc2, popd, yv);
      n++;
    end
    ys   = yv;
    done = popd;
  endtask

  initial begin
    vec_t tbl[6];
    logic [W-1:0] ys;
    logic done, acc, popd;
    logic [W-1:0] set_a[10], set_b[10];
    int nacc, npop, n;

    tbl[0] = '{a: 8'h03, b: 8'h04, c: 8'h05, d: 8'h06, bias: 8'h07, exp_y: 8'h31};
    tbl[1] = '{a: 8'hFE, b: 8'h03, c: 8'h00, d: 8'h00, bias: 8'h00, exp_y: 8'hFA};
    tbl[2] = '{a: 8'h7F, b: 8'h7F, c: 8'h00, d: 8'h00, bias: 8'h00, exp_y: 8'h01};
    tbl[3] = '{a: 8'h80, b: 8'h80, c: 8'h80, d: 8'h80, bias: 8'h80, exp_y: 8'h80};
    tbl[4] = '{a: 8'hFF, b: 8'hFF, c: 8'h01, d: 8'hFF, bias: 8'h10, exp_y: 8'h10};
    tbl[5] = '{a: 8'h10, b: 8'h10, c: 8'h00, d: 8'h00, bias: 8'h00, exp_y: 8'h00};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.bias = '0;

    // Reset
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, acc, popd, ys);
    idle(1'b0);

    // Table vectors (single op, sign, wrap)
    for (int i = 0; i < 6; i++) begin
      apply_one(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].bias, ys, done);
      check($sformatf("table_done_%0d", i), done, 1'b1);
      check($sformatf("table_y_%0d", i), ys, tbl[i].exp_y);
      if (i == 0) begin
        idle(1'b1);
        check("single_busy_after_pop", bus.busy, 1'b0);
      end
    end

    // Backpressure: 10 distinct sets held at the input, consumer stalled
    for (int i = 0; i < 10; i++) begin
      set_a[i] = W'(i + 1);
      set_b[i] = W'(3 * i + 2);
    end
    nacc = 0; npop = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 1'b1, set_a[nacc], set_b[nacc], 8'h01, 8'h02, 8'h05, 1'b0, acc, popd, ys);
      if (acc) nacc++;
    end
    check("bp_accepted", nacc, DEPTH);
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    n = 0;
    while ((nacc < 10 || q.size() != 0) && n < 100) begin
      cycle(1'b1, nacc < 10, set_a[nacc % 10], set_b[nacc % 10], 8'h01, 8'h02, 8'h05,
            1'b1, acc, popd, ys);
      if (acc) nacc++;
      if (popd) npop++;
      n++;
    end
    check("bp_total_accepted", nacc, 10);
    check("bp_total_popped", npop, 10);

    // Continuous traffic, random operands
    nacc = 0; n = 0;
    while (nacc < 100 && n < 300) begin
      cycle(1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            W'($urandom), 1'b1, acc, popd, ys);
      if (acc) nacc++;
      n++;
    end
    check("stream_accepted", nacc, 100);
    for (int k = 0; k < 8; k++) idle(1'b1);
    check("stream_drained", q.size(), 0);

    // Reset mid-stream before the first result appears
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 1'b1, acc, popd, ys);
    cycle(1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 1'b1, acc, popd, ys);
    idle(1'b1);
    check("post_reset_in_ready", bus.in_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      idle(1'b1);
      check("post_reset_no_stale", bus.out_valid, 1'b0);
    end
    apply_one(8'h01, 8'h01, 8'h00, 8'h00, 8'h00, ys, done);
    check("post_reset_done", done, 1'b1);
    check("post_reset_y", ys, 8'h01);

    // Random valid / random out_ready across FIFO wrap
    nacc = 0; n = 0;
    while (nacc < 200 && n < 3000) begin
      cycle(1'b1, $urandom_range(0, 3) != 0, W'($urandom), W'($urandom), W'($urandom),
            W'($urandom), W'($urandom), $urandom_range(0, 1) == 1, acc, popd, ys);
      if (acc) nacc++;
      n++;
    end
    check("random_accepted", nacc, 200);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    check("random_drained", q.size(), 0);
    idle(1'b1);
    check("final_busy", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
